// File: rtl/param_sync_fifo.sv
// param_sync_fifo
//   Single-clock synchronous FIFO with DEPTH x WIDTH storage.
//   - Registered occupancy count and status flags.
//   - Sticky overflow and underflow error flags.
//   - Selectable read mode:
//       FWFT=0 : data_out loads on an accepted read (one-cycle latency).
//       FWFT=1 : data_out shows the head word whenever the FIFO is not empty.
//
// Ports
//   clk          : single clock, rising edge
//   async_rst    : asynchronous active-low reset
//   flush        : synchronous empty request; has priority over write_en and read_en
//   data_in      : write data (WIDTH bits)
//   write_en     : write request, accepted when not full
//   read_en      : read (pop) request, accepted when not empty
//   data_out     : read data (WIDTH bits)
//   full / empty / almost_full / almost_empty : registered status flags
//   count        : registered occupancy, 0..DEPTH
//   overflow     : sticky; set by a write while full, cleared by flush or reset
//   underflow    : sticky; set by a read while empty, cleared by flush or reset
module param_sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   async_rst,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   write_en,
  input  logic                   read_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [PW-1:0] ZERO_C  = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_C   = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Pointers carry one extra MSB so that full and empty can be told apart.
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    count_r;
  logic [WIDTH-1:0] data_out_r;
  logic             full_r;
  logic             empty_r;
  logic             af_r;
  logic             ae_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             wr_acc_s;
  logic             rd_acc_s;
  logic [PW-1:0]    wr_ptr_nxt_s;
  logic [PW-1:0]    rd_ptr_nxt_s;
  logic [PW-1:0]    count_nxt_s;
  logic [WIDTH-1:0] data_out_nxt_s;
  logic             overflow_nxt_s;
  logic             underflow_nxt_s;

  // Decide which operations are accepted this cycle, and compute the next state.
  always_comb begin
    wr_acc_s        = 1'b0;
    rd_acc_s        = 1'b0;
    wr_ptr_nxt_s    = wr_ptr_r;
    rd_ptr_nxt_s    = rd_ptr_r;
    count_nxt_s     = count_r;
    data_out_nxt_s  = data_out_r;
    overflow_nxt_s  = overflow_r;
    underflow_nxt_s = underflow_r;

    if (flush) begin
      wr_ptr_nxt_s    = ZERO_C;
      rd_ptr_nxt_s    = ZERO_C;
      count_nxt_s     = ZERO_C;
      overflow_nxt_s  = 1'b0;
      underflow_nxt_s = 1'b0;
    end else begin
      wr_acc_s = write_en & ~full_r;
      rd_acc_s = read_en & ~empty_r;

      if (write_en & full_r) begin
        overflow_nxt_s = 1'b1;
      end else begin
        overflow_nxt_s = overflow_r;
      end

      if (read_en & empty_r) begin
        underflow_nxt_s = 1'b1;
      end else begin
        underflow_nxt_s = underflow_r;
      end

      if (wr_acc_s) begin
        wr_ptr_nxt_s = wr_ptr_r + ONE_C;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end

      if (rd_acc_s) begin
        rd_ptr_nxt_s = rd_ptr_r + ONE_C;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end

      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_nxt_s = count_r + ONE_C;
        2'b01:   count_nxt_s = count_r - ONE_C;
        default: count_nxt_s = count_r;
      endcase

      if (FWFT != 0) begin
        // Preload the word that will be at the head after this edge. When that
        // word is being written on this same edge, it is not in memory yet, so
        // it is taken from data_in instead.
        if (count_nxt_s != ZERO_C) begin
          if (wr_acc_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            data_out_nxt_s = data_in;
          end else begin
            data_out_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
          end
        end else begin
          data_out_nxt_s = data_out_r;
        end
      end else begin
        if (rd_acc_s) begin
          data_out_nxt_s = mem_r[rd_ptr_r[AW-1:0]];
        end else begin
          data_out_nxt_s = data_out_r;
        end
      end
    end
  end

  // Storage array. It has no reset; the pointers alone determine which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= data_in;
    end
  end

  // Pointers, count, read data, flags and sticky errors. The flags are
  // registered from the next count, so they never glitch.
  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      wr_ptr_r    <= ZERO_C;
      rd_ptr_r    <= ZERO_C;
      count_r     <= ZERO_C;
      data_out_r  <= {WIDTH{1'b0}};
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      af_r        <= 1'b0;
      ae_r        <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      data_out_r  <= data_out_nxt_s;
      full_r      <= (count_nxt_s == DEPTH_C);
      empty_r     <= (count_nxt_s == ZERO_C);
      af_r        <= (count_nxt_s >= AF_C);
      ae_r        <= (count_nxt_s <= AE_C);
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  assign data_out     = data_out_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Testbench for param_sync_fifo.
//   Two instances (FWFT=0 and FWFT=1) share one stimulus stream.
//   A queue-based reference model predicts the state after every clock edge
//   and pushes the prediction into a scoreboard queue. A separate monitor pops
//   each prediction just after the edge and compares it with both instances.
module tb_param_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic         clk = 1'b0;
  logic         async_rst = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] data_in = 8'h00;
  logic         write_en = 1'b0;
  logic         read_en = 1'b0;

  logic [W-1:0] dout0, dout1;
  logic         full0, empty0, af0, ae0, ov0, un0;
  logic         full1, empty1, af1, ae1, ov1, un1;
  logic [2:0]   cnt0, cnt1;

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_dut0 (
    .clk(clk), .async_rst(async_rst), .flush(flush), .data_in(data_in),
    .write_en(write_en), .read_en(read_en), .data_out(dout0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ov0), .underflow(un0)
  );

  param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_dut1 (
    .clk(clk), .async_rst(async_rst), .flush(flush), .data_in(data_in),
    .write_en(write_en), .read_en(read_en), .data_out(dout1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ov1), .underflow(un1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ov;
    logic        un;
    logic [7:0]  d0;
    logic        chk1;
    logic [7:0]  d1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state
  logic [7:0] m_q[$];
  logic       m_ov = 1'b0;
  logic       m_un = 1'b0;
  logic [7:0] m_d0 = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Advance the model by one clock edge and queue the predicted outcome.
  task automatic model_step(input logic we, input logic re, input logic fl, input logic [7:0] din);
    exp_t e;
    int   sz;
    if (fl) begin
      m_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      sz = m_q.size();
      if (we && sz == D) m_ov = 1'b1;
      if (re && sz == 0) m_un = 1'b1;
      if (re && sz > 0) m_d0 = m_q.pop_front();
      if (we && sz < D) m_q.push_back(din);
    end
    sz     = m_q.size();
    e.cnt  = sz;
    e.full = (sz == D);
    e.empty = (sz == 0);
    e.af   = (sz >= AF);
    e.ae   = (sz <= AE);
    e.ov   = m_ov;
    e.un   = m_un;
    e.d0   = m_d0;
    e.chk1 = (sz > 0);
    e.d1   = (sz > 0) ? m_q[0] : 8'h00;
    exp_q.push_back(e);
  endtask

  // Run one cycle: drive the inputs on the falling edge, then predict.
  task automatic cyc(input logic we, input logic re, input logic fl, input logic [7:0] din);
    @(negedge clk);
    write_en = we;
    read_en  = re;
    flush    = fl;
    data_in  = din;
    model_step(we, re, fl, din);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt0"}, {29'd0, cnt0}, 32'd0);
    chk({tag, "_cnt1"}, {29'd0, cnt1}, 32'd0);
    chk({tag, "_flags0"}, {26'd0, full0, empty0, af0, ae0, ov0, un0}, 32'b010100);
    chk({tag, "_flags1"}, {26'd0, full1, empty1, af1, ae1, ov1, un1}, 32'b010100);
    chk({tag, "_dout0"}, {24'd0, dout0}, 32'd0);
    chk({tag, "_dout1"}, {24'd0, dout1}, 32'd0);
  endtask

  // Pulse the asynchronous reset between clock edges and check that it acts at once.
  task automatic rst_pulse();
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    flush    = 1'b0;
    #1 async_rst = 1'b0;
    #1 chk_reset_vals("midrst");
    m_q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    m_d0 = 8'h00;
    #1 async_rst = 1'b1;
    model_step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Scoreboard monitor: just after each rising edge, compare the DUTs with the next prediction.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("count0", {29'd0, cnt0}, mon_e.cnt);
      chk("count1", {29'd0, cnt1}, mon_e.cnt);
      chk("flags0", {26'd0, full0, empty0, af0, ae0, ov0, un0},
          {26'd0, mon_e.full, mon_e.empty, mon_e.af, mon_e.ae, mon_e.ov, mon_e.un});
      chk("flags1", {26'd0, full1, empty1, af1, ae1, ov1, un1},
          {26'd0, mon_e.full, mon_e.empty, mon_e.af, mon_e.ae, mon_e.ov, mon_e.un});
      chk("dout0", {24'd0, dout0}, {24'd0, mon_e.d0});
      if (mon_e.chk1) chk("dout1_head", {24'd0, dout1}, {24'd0, mon_e.d1});
    end
  end

  initial begin
    logic [7:0] v;
    #12 chk_reset_vals("reset");
    @(negedge clk);
    async_rst = 1'b1;

    // Fill to full, then read back in order.
    cyc(1'b1, 1'b0, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 1'b0, 8'h22);
    cyc(1'b1, 1'b0, 1'b0, 8'h33);
    cyc(1'b1, 1'b0, 1'b0, 8'h44);
    // A write while full is dropped and sets overflow.
    cyc(1'b1, 1'b0, 1'b0, 8'h55);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    // A read while empty sets underflow; then read and write together on an empty FIFO.
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 1'b0, 8'hAA);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    // Flush clears the sticky flags.
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    // First-word-fall-through: a single write, then one read.
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    // Hold count at 2 with simultaneous read and write across pointer wrap.
    cyc(1'b1, 1'b0, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 1'b0, 8'h02);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
    // Reach count 3 with overflow set, then flush while writing.
    cyc(1'b1, 1'b0, 1'b0, 8'h03);
    cyc(1'b1, 1'b0, 1'b0, 8'h04);
    cyc(1'b1, 1'b0, 1'b0, 8'h05);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'h66);
    // Asynchronous reset in the middle of traffic.
    cyc(1'b1, 1'b0, 1'b0, 8'h77);
    cyc(1'b1, 1'b0, 1'b0, 8'h88);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    rst_pulse();
    cyc(1'b1, 1'b0, 1'b0, 8'h99);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);

    // Random traffic in phases that favour writes, reads, or balanced traffic.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 250; i++) begin
        int wp;
        int rp;
        wp = (p % 3 == 0) ? 75 : ((p % 3 == 1) ? 25 : 50);
        rp = 100 - wp;
        v  = 8'($urandom_range(0, 255));
        cyc(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
            ($urandom_range(0, 99) < 2), v);
      end
      if (p == 3) rst_pulse();
    end

    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
